// File: rtl/audio_pkg.sv
// Shared types for the alarm-clock sound scheduler: event sources, FSM states
// and the pending-bit helpers used by the priority logic.
package audio_pkg;

  // Encoding order doubles as priority rank: larger value wins.
  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_OCLOCK  = 2'd1,
    SRC_ALARM   = 2'd2,
    SRC_WARNING = 2'd3
  } source_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } sched_state_t;

  localparam logic [31:0] FREQ_SILENT = 32'd0;

  // Pending vector layout: bit 2 warning, bit 1 alarm, bit 0 oclock.
  function automatic logic [2:0] src_mask(input source_t s);
    case (s)
      SRC_WARNING: src_mask = 3'b100;
      SRC_ALARM:   src_mask = 3'b010;
      SRC_OCLOCK:  src_mask = 3'b001;
      default:     src_mask = 3'b000;
    endcase
  endfunction

  function automatic source_t top_source(input logic [2:0] p);
    if (p[2])      top_source = SRC_WARNING;
    else if (p[1]) top_source = SRC_ALARM;
    else if (p[0]) top_source = SRC_OCLOCK;
    else           top_source = SRC_NONE;
  endfunction

endpackage

// File: rtl/beep_timer.sv
// Tick-period counter for one tone or gap; done fires on the tick that
// completes the programmed number of periods.
module beep_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        tick,
  input  logic [15:0] limit,
  output logic        done
);

  logic [15:0] count_reg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_reg <= 16'd0;
    end else if (tick) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign done = tick && (count_reg == limit - 16'd1);

endmodule

// File: rtl/audio_event_scheduler.sv
// Prioritised, preemptive beep scheduler driving the buzzer tone code from
// warning, alarm and hour-chime request pulses.
module audio_event_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned  BEEP_TICKS    = 200,
  parameter int unsigned  GAP_TICKS     = 100,
  parameter int unsigned  WARNING_BEEPS = 1,
  parameter int unsigned  OCLOCK_BEEPS  = 2,
  parameter int unsigned  ALARM_BEEPS   = 30,
  parameter logic [31:0]  WARNING_FREQ  = 32'd4,
  parameter logic [31:0]  ALARM_FREQ    = 32'd2,
  parameter logic [31:0]  OCLOCK_FREQ   = 32'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        warning,
  input  logic        alarm,
  input  logic        oclock,
  input  logic        no_response,
  output logic [31:0] frequency_select,
  output logic        busy,
  output logic [1:0]  active_source
);

  localparam logic [15:0] BEEP_LIMIT = 16'(BEEP_TICKS);
  localparam logic [15:0] GAP_LIMIT  = 16'(GAP_TICKS);
  localparam logic [7:0]  WARNING_N  = 8'(WARNING_BEEPS);
  localparam logic [7:0]  OCLOCK_N   = 8'(OCLOCK_BEEPS);
  localparam logic [7:0]  ALARM_N    = 8'(ALARM_BEEPS);

  sched_state_t state_reg;
  source_t      cur_src_reg;
  logic [2:0]   pending_reg;
  logic [7:0]   beep_reg;
  logic [31:0]  freq_reg;
  logic         busy_reg;

  logic [2:0]   req_mask;
  source_t      top_src;
  logic [1:0]   top_rank;
  logic [1:0]   cur_rank;
  logic         preempt;
  logic         last_beep;
  logic [15:0]  timer_limit;
  logic         timer_clear;
  logic         timer_done;

  function automatic logic [31:0] freq_of(input source_t s);
    case (s)
      SRC_WARNING: freq_of = WARNING_FREQ;
      SRC_ALARM:   freq_of = ALARM_FREQ;
      SRC_OCLOCK:  freq_of = OCLOCK_FREQ;
      default:     freq_of = FREQ_SILENT;
    endcase
  endfunction

  function automatic logic [7:0] beats_of(input source_t s);
    case (s)
      SRC_WARNING: beats_of = WARNING_N;
      SRC_ALARM:   beats_of = ALARM_N;
      SRC_OCLOCK:  beats_of = OCLOCK_N;
      default:     beats_of = 8'd1;
    endcase
  endfunction

  assign req_mask  = {warning, alarm, oclock};
  assign top_src   = top_source(pending_reg);
  assign top_rank  = top_src;
  assign cur_rank  = cur_src_reg;
  assign preempt   = (state_reg != S_IDLE) && (top_rank > cur_rank);
  assign last_beep = (beep_reg == beats_of(cur_src_reg) - 8'd1);

  // The counter restarts on every state change; holding it cleared in IDLE
  // keeps it at zero for the first TONE period.
  assign timer_limit = (state_reg == S_TONE) ? BEEP_LIMIT : GAP_LIMIT;
  assign timer_clear = no_response || (state_reg == S_IDLE) || preempt || timer_done;

  beep_timer u_beep_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clear),
    .tick  (tick),
    .limit (timer_limit),
    .done  (timer_done)
  );

  always_ff @(posedge clock) begin
    if (reset || no_response) begin
      state_reg   <= S_IDLE;
      cur_src_reg <= SRC_NONE;
      pending_reg <= 3'b000;
      beep_reg    <= 8'd0;
      freq_reg    <= FREQ_SILENT;
      busy_reg    <= 1'b0;
    end else begin
      pending_reg <= pending_reg | req_mask;
      case (state_reg)
        S_IDLE: begin
          if (top_src != SRC_NONE) begin
            state_reg   <= S_TONE;
            cur_src_reg <= top_src;
            pending_reg <= (pending_reg & ~src_mask(top_src)) | req_mask;
            beep_reg    <= 8'd0;
            freq_reg    <= freq_of(top_src);
            busy_reg    <= 1'b1;
          end
        end
        S_TONE, S_GAP: begin
          if (preempt) begin
            // Interrupted source goes back in the queue and restarts from beep 0.
            state_reg   <= S_TONE;
            cur_src_reg <= top_src;
            pending_reg <= (pending_reg & ~src_mask(top_src)) | src_mask(cur_src_reg) | req_mask;
            beep_reg    <= 8'd0;
            freq_reg    <= freq_of(top_src);
          end else if (timer_done) begin
            if (state_reg == S_TONE) begin
              freq_reg <= FREQ_SILENT;
              if (last_beep) begin
                state_reg   <= S_IDLE;
                cur_src_reg <= SRC_NONE;
                beep_reg    <= 8'd0;
                busy_reg    <= 1'b0;
              end else begin
                state_reg <= S_GAP;
              end
            end else begin
              state_reg <= S_TONE;
              beep_reg  <= beep_reg + 8'd1;
              freq_reg  <= freq_of(cur_src_reg);
            end
          end
        end
        default: begin
          state_reg   <= S_IDLE;
          cur_src_reg <= SRC_NONE;
          freq_reg    <= FREQ_SILENT;
          busy_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign frequency_select = freq_reg;
  assign busy             = busy_reg;
  assign active_source    = cur_src_reg;

endmodule

// File: tb/tb_audio_event_scheduler.sv
// Directed bench: chime, preemption, queueing, silence, reset and the
// 255-beep limit case on a second instance with 1-tick timing.
module tb_audio_event_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        tick_a, warning_a, alarm_a, oclock_a, nr_a;
  logic [31:0] freq_a;
  logic        busy_a;
  logic [1:0]  src_a;
  logic        tick_b, warning_b, alarm_b, oclock_b, nr_b;
  logic [31:0] freq_b;
  logic        busy_b;
  logic [1:0]  src_b;

  audio_event_scheduler #(.BEEP_TICKS(3), .GAP_TICKS(2)) dut_a (
    .clock(clock), .reset(reset), .tick(tick_a), .warning(warning_a),
    .alarm(alarm_a), .oclock(oclock_a), .no_response(nr_a),
    .frequency_select(freq_a), .busy(busy_a), .active_source(src_a)
  );

  audio_event_scheduler #(.BEEP_TICKS(1), .GAP_TICKS(1), .ALARM_BEEPS(255)) dut_b (
    .clock(clock), .reset(reset), .tick(tick_b), .warning(warning_b),
    .alarm(alarm_b), .oclock(oclock_b), .no_response(nr_b),
    .frequency_select(freq_b), .busy(busy_b), .active_source(src_b)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int tone_cnt = 0;
  int codes[64];
  int starts[64];
  int lens[64];
  logic [31:0] prev_a = 32'd0;
  logic [31:0] prev_b = 32'd0;
  int tone_b = 0;
  int max_beep_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, got);
    end
  endtask

  // Advance one clock, sample outputs 1 time unit after the edge, track tones.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (freq_a != 32'd0 && freq_a != prev_a) begin
      if (tone_cnt < 64) begin
        codes[tone_cnt]  = int'(freq_a);
        starts[tone_cnt] = cyc;
        lens[tone_cnt]   = 0;
      end
      tone_cnt++;
    end
    if (freq_a != 32'd0 && tone_cnt <= 64) lens[tone_cnt-1]++;
    prev_a = freq_a;
    if (freq_b != 32'd0 && prev_b == 32'd0) tone_b++;
    prev_b = freq_b;
    if (int'(dut_b.beep_reg) > max_beep_b) max_beep_b = int'(dut_b.beep_reg);
    tick_a = (cyc % 4 == 0);
  endtask

  task automatic wait_tones(input int target, input int bound, input string tag);
    for (int i = 0; i < bound && tone_cnt < target; i++) step();
    check(tag, tone_cnt, target);
  endtask

  task automatic wait_idle_a(input int bound, input string tag);
    for (int i = 0; i < bound && busy_a; i++) step();
    check(tag, {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    tick_a = 1'b0; warning_a = 1'b0; alarm_a = 1'b0; oclock_a = 1'b0; nr_a = 1'b0;
    tick_b = 1'b1; warning_b = 1'b0; alarm_b = 1'b0; oclock_b = 1'b0; nr_b = 1'b0;
    step();
    step();
    check("reset_freq", freq_a, 32'd0);
    check("reset_busy", {31'd0, busy_a}, 32'd0);
    check("reset_src", {30'd0, src_a}, 32'd0);
    check("reset_freq_b", freq_b, 32'd0);
    reset = 1'b0;
    step();

    // Hour chime: two tones of code 1 separated by an 8-cycle gap.
    tone_cnt = 0;
    oclock_a = 1'b1; step(); oclock_a = 1'b0;
    check("chime_pending_only", freq_a, 32'd0);
    step();
    check("chime_code", freq_a, 32'd1);
    check("chime_src", {30'd0, src_a}, 32'd1);
    check("chime_busy", {31'd0, busy_a}, 32'd1);
    wait_idle_a(200, "chime_done");
    repeat (10) step();
    check("chime_tones", tone_cnt, 2);
    check("chime_code2", codes[1], 1);
    check("chime_len0_in_9_12", {31'd0, (lens[0] >= 9 && lens[0] <= 12)}, 32'd1);
    check("chime_len1", lens[1], 12);
    check("chime_gap", starts[1] - (starts[0] + lens[0]), 8);
    check("chime_src_after", {30'd0, src_a}, 32'd0);

    // Alarm preempted by warning during beep 5, then restarts from beep 0.
    tone_cnt = 0;
    alarm_a = 1'b1; step(); alarm_a = 1'b0;
    wait_tones(6, 400, "alarm_reach_beep5");
    warning_a = 1'b1; step(); warning_a = 1'b0;
    check("preempt_hold", freq_a, 32'd2);
    step();
    check("preempt_code", freq_a, 32'd4);
    check("preempt_src", {30'd0, src_a}, 32'd3);
    wait_tones(37, 1500, "preempt_all_tones");
    wait_idle_a(100, "preempt_done");
    repeat (10) step();
    check("preempt_total", tone_cnt, 37);
    check("preempt_warn_tone", codes[6], 4);
    check("preempt_restart_code", codes[7], 2);
    check("preempt_last_code", codes[36], 2);

    // Chime requested during warning starts one cycle after it ends.
    tone_cnt = 0;
    warning_a = 1'b1; step(); warning_a = 1'b0;
    wait_tones(1, 10, "queue_warn_start");
    oclock_a = 1'b1; step(); oclock_a = 1'b0;
    wait_tones(3, 300, "queue_tones");
    wait_idle_a(100, "queue_done");
    check("queue_first", codes[0], 4);
    check("queue_second", codes[1], 1);
    check("queue_idle_gap", starts[1] - (starts[0] + lens[0]), 1);

    // Button press mid-alarm silences and drops a same-cycle request.
    tone_cnt = 0;
    alarm_a = 1'b1; step(); alarm_a = 1'b0;
    wait_tones(3, 200, "silence_reach");
    nr_a = 1'b1; alarm_a = 1'b1; step(); nr_a = 1'b0; alarm_a = 1'b0;
    check("silence_freq", freq_a, 32'd0);
    check("silence_busy", {31'd0, busy_a}, 32'd0);
    check("silence_pending", {29'd0, dut_a.pending_reg}, 32'd0);
    repeat (100) step();
    check("silence_no_more", tone_cnt, 3);

    // Reset during TONE, then a warning gives a tone two cycles later.
    tone_cnt = 0;
    alarm_a = 1'b1; step(); alarm_a = 1'b0;
    wait_tones(1, 10, "reset_alarm_start");
    repeat (3) step();
    check("reset_pre_tone", freq_a, 32'd2);
    reset = 1'b1; step(); reset = 1'b0;
    check("midreset_freq", freq_a, 32'd0);
    check("midreset_busy", {31'd0, busy_a}, 32'd0);
    check("midreset_src", {30'd0, src_a}, 32'd0);
    warning_a = 1'b1; step(); warning_a = 1'b0;
    check("postreset_lat1", freq_a, 32'd0);
    step();
    check("postreset_tone", freq_a, 32'd4);
    wait_idle_a(100, "postreset_done");

    // 255 one-tick beeps on instance B; beep counter must stop at 254.
    alarm_b = 1'b1; step(); alarm_b = 1'b0;
    step();
    check("limit_first_tone", freq_b, 32'd2);
    for (int i = 0; i < 1000 && busy_b; i++) step();
    repeat (20) step();
    check("limit_tones", tone_b, 255);
    check("limit_max_beep", max_beep_b, 254);
    check("limit_busy", {31'd0, busy_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/audio_event_scheduler.md
# audio_event_scheduler

Arbitrates the single buzzer between the three sound-event sources of the alarm clock (keyboard/pointer warning, alarm match, on-the-hour chime) and sequences each event as a timed beep pattern. It sits between the event-detection logic of the controller and the tone generator, replacing a purely combinational frequency mux with a prioritised, preemptive beep scheduler. Any button press silences the buzzer immediately.

## Interface
- `BEEP_TICKS`, default 200: tone-on duration per beep, in `tick` pulses (range 1..65535).
- `GAP_TICKS`, default 100: silence between beeps, in `tick` pulses (range 1..65535).
- `WARNING_BEEPS`, default 1: beeps per warning event (range 1..255).
- `OCLOCK_BEEPS`, default 2: beeps per hour chime (range 1..255).
- `ALARM_BEEPS`, default 30: beeps per alarm event (range 1..255).
- `WARNING_FREQ`, default 32'd4: `frequency_select` code for warning tone.
- `ALARM_FREQ`, default 32'd2: code for alarm tone.
- `OCLOCK_FREQ`, default 32'd1: code for chime tone.
- `clock` input 1: system clock; the single clock of the block.
- `reset` input 1: reset, synchronous and active-high.
- `tick` input 1: one-cycle timebase strobe (1 kHz nominal).
- `warning` input 1: warning request pulse.
- `alarm` input 1: alarm request pulse.
- `oclock` input 1: hour-chime request pulse.
- `no_response` input 1: silence/acknowledge; any button down.
- `frequency_select` output 32: registered tone code; 0 = silent.
- `busy` output 1: a sequence is in TONE or GAP.
- `active_source` output 2: 0 none, 1 oclock, 2 alarm, 3 warning.

## Operation
- Priority: warning > alarm > oclock.
- Request pulses set the matching bit of a 3-bit `pending` register. A level held high re-sets the bit every cycle.
- FSM states:
  - IDLE: `frequency_select` = 0.
  - TONE: `frequency_select` = source frequency.
  - GAP: `frequency_select` = 0.
- IDLE -> TONE when `pending` is nonzero. The highest-priority pending source is selected, its pending bit is cleared, the beep counter is set to 0 and the tick counter to 0.
- TONE -> GAP on the edge where `tick`=1 and the tick count equals `BEEP_TICKS-1`. If this was the last beep (beep count = N-1), the transition is TONE -> IDLE instead.
- GAP -> TONE on `tick`=1 with the tick count equal to `GAP_TICKS-1`; the beep counter increments.
- The tick counter resets on every state change.
- Preemption: if a strictly higher-priority bit is pending while in TONE or GAP, at the next edge the current source's pending bit is re-set, and the higher source starts in TONE from beep 0. A preempted sequence restarts from the beginning later.
- A same-or-lower-priority request during playback only sets its pending bit; it is served after the current sequence completes.
- `no_response`=1: at the next edge go to IDLE, clear all pending bits and the counters, and set `frequency_select` to 0. It overrides any request in the same cycle; that request is dropped.
- Counter widths: 16-bit tick counter, 8-bit beep counter; no wrap occurs within the legal parameter ranges.

## Timing
- Reset values: `frequency_select`=0, `busy`=0, `active_source`=0, `pending`=0, state IDLE, both counters 0.
- Reset mid-sequence: all of the above at the next edge; reset dominates `no_response` and requests.
- Latency:
  - Request sampled at edge k sets `pending` at k.
  - Edge k+1 enters TONE; the outputs are valid after k+1.
  - The 2-cycle request-to-tone latency holds only from IDLE.
- Tone length = `BEEP_TICKS` tick periods, measured from the first `tick` after TONE entry. The first partial period counts as part of the tone, so the first tone is between `BEEP_TICKS-1` and `BEEP_TICKS` tick periods.
- All outputs are registered; no combinational path from inputs to outputs.
- `tick` asserted on consecutive cycles counts each cycle.

## Structure
- Package `audio_pkg`:
  - `source_t` enum {SRC_NONE, SRC_OCLOCK, SRC_ALARM, SRC_WARNING}.
  - `sched_state_t` enum {S_IDLE, S_TONE, S_GAP}.
  - `FREQ_SILENT`=32'd0.
- One sub-module, `beep_timer`: 16-bit tick counter with `clear`, `tick`, `limit` inputs and a `done` output (`tick` & count==`limit`-1).
- Priority encoding and the FSM live in `audio_event_scheduler`. Expected size ~200 lines.

## Test plan
- Chime: with BEEP=3, GAP=2, `tick` every 4 cycles, pulse `oclock` -> 2 tones of code 1 separated by silence, then `busy`=0 and `active_source`=0.
- Preemption: with an alarm playing beep 5, pulse `warning` -> next edge code 4 for 1 beep, then alarm restarts at beep 0 with code 2.
- Queueing: `oclock` during warning playback -> chime begins immediately after warning completes (no idle gap beyond 1 cycle).
- Silence: with `no_response`=1 and `alarm`=1 in the same cycle mid-alarm -> next edge `frequency_select`=0, `pending`=0, and no later tone.
- Reset: assert `reset` for 1 cycle during TONE -> all outputs 0 next edge; a subsequent `warning` pulse gives a tone after 2 cycles.
- Limits: BEEP_TICKS=1, GAP_TICKS=1, ALARM_BEEPS=255 -> exactly 255 tones, and the 8-bit beep counter terminates without wrap.
